// File: rtl/fp_issue_scoreboard_pkg.sv
// Shared definitions for the FP issue stage: register space, FU function codes
// and the div/sqrt occupancy FSM encoding.
package fp_issue_scoreboard_pkg;

   localparam int unsigned VIR_REG_ADDR_WIDTH = 6;
   localparam int unsigned FU_FUNC_WIDTH      = 5;

   localparam logic [FU_FUNC_WIDTH-1:0] FU_FADD     = 5'd0;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FSUB     = 5'd1;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMUL     = 5'd2;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMADD    = 5'd3;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMSUB    = 5'd4;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FNMSUB   = 5'd5;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FNMADD   = 5'd6;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FSGNJ    = 5'd7;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMINMAX  = 5'd8;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FCMP     = 5'd9;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FCLASS   = 5'd10;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FCVT_W_S = 5'd11;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FCVT_S_W = 5'd12;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMV_X_W  = 5'd13;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FMV_W_X  = 5'd14;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FDIV     = 5'd26;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FSQRT    = 5'd27;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FLW      = 5'd28;
   localparam logic [FU_FUNC_WIDTH-1:0] FU_FSW      = 5'd29;

   localparam logic [0:0] D_IDLE = 1'b0;
   localparam logic [0:0] D_BUSY = 1'b1;

endpackage

// File: rtl/fp_scoreboard.sv
// In-flight destination tracker: one bit per virtual register, with the
// same-cycle writeback bypassed into every pending lookup.
module fp_scoreboard
   import fp_issue_scoreboard_pkg::*;
#(
   parameter int unsigned ADDR_W = VIR_REG_ADDR_WIDTH,
   parameter int unsigned NUM_RD = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr_valid_i,
   input  logic [ADDR_W-1:0]             clr_addr_i,
   input  logic                          set_valid_i,
   input  logic [ADDR_W-1:0]             set_addr_i,
   input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]             pending_o
);

   localparam int unsigned NumEntries = 2 ** ADDR_W;

   logic [NumEntries-1:0] sb_q, sb_d;

   // Set is applied after clear so a same-address collision leaves the bit set.
   always_comb begin
      sb_d = sb_q;
      if (clr_valid_i) begin
         sb_d[clr_addr_i] = 1'b0;
      end
      if (set_valid_i && (set_addr_i != '0)) begin
         sb_d[set_addr_i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         pending_o[i] = sb_q[rd_addr_i[i]] & ~(clr_valid_i && (clr_addr_i == rd_addr_i[i]));
      end
   end

endmodule

// File: rtl/fp_issue_scoreboard.sv
// Single-entry FP issue stage: holds one decoded op until RAW/WAW/div hazards
// clear, serialises the div/sqrt unit and counts hazard-stall cycles.
module fp_issue_scoreboard #(
   parameter int unsigned VIR_REG_ADDR_WIDTH = fp_issue_scoreboard_pkg::VIR_REG_ADDR_WIDTH,
   parameter int unsigned FU_FUNC_WIDTH      = fp_issue_scoreboard_pkg::FU_FUNC_WIDTH,
   parameter int unsigned STALL_CNT_WIDTH    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_uses_rs1,
   input  logic                          in_uses_rs2,
   input  logic                          in_uses_rs3,
   input  logic                          in_uses_rd,
   input  logic [VIR_REG_ADDR_WIDTH-1:0] in_rs1,
   input  logic [VIR_REG_ADDR_WIDTH-1:0] in_rs2,
   input  logic [VIR_REG_ADDR_WIDTH-1:0] in_rs3,
   input  logic [VIR_REG_ADDR_WIDTH-1:0] in_rd,
   input  logic [11:0]                   in_imm,
   input  logic [FU_FUNC_WIDTH-1:0]      in_func,
   output logic                          iss_valid,
   input  logic                          iss_ready,
   output logic [VIR_REG_ADDR_WIDTH-1:0] iss_rs1,
   output logic [VIR_REG_ADDR_WIDTH-1:0] iss_rs2,
   output logic [VIR_REG_ADDR_WIDTH-1:0] iss_rs3,
   output logic [VIR_REG_ADDR_WIDTH-1:0] iss_rd,
   output logic [11:0]                   iss_imm,
   output logic [FU_FUNC_WIDTH-1:0]      iss_func,
   input  logic                          wb_valid,
   input  logic [VIR_REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic                          div_done,
   input  logic                          flush,
   output logic                          div_busy,
   output logic [STALL_CNT_WIDTH-1:0]    stall_cnt
);

   import fp_issue_scoreboard_pkg::*;

   logic                          hold_v_q, hold_v_d;
   logic [3:0]                    uses_q;
   logic [VIR_REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rs3_q, rd_q;
   logic [11:0]                   imm_q;
   logic [FU_FUNC_WIDTH-1:0]      func_q;
   logic [0:0]                    div_state_q, div_state_d;
   logic [STALL_CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
   logic [3:0]                    pending;
   logic                          is_div, hazard, fire, accept;

   fp_scoreboard #(
      .ADDR_W (VIR_REG_ADDR_WIDTH),
      .NUM_RD (4)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .clr_valid_i (wb_valid),
      .clr_addr_i  (wb_rd),
      .set_valid_i (fire & uses_q[3]),
      .set_addr_i  (rd_q),
      .rd_addr_i   ({rd_q, rs3_q, rs2_q, rs1_q}),
      .pending_o   (pending)
   );

   assign is_div = (func_q == FU_FUNC_WIDTH'(FU_FDIV)) || (func_q == FU_FUNC_WIDTH'(FU_FSQRT));
   assign div_busy = (div_state_q == D_BUSY);
   // uses_q is {rd, rs3, rs2, rs1}, lined up with the scoreboard read ports.
   assign hazard = (|(pending & uses_q)) | (is_div & div_busy);
   assign iss_valid = hold_v_q & ~hazard & ~flush;
   assign fire = iss_valid & iss_ready;
   assign in_ready = (~hold_v_q | fire) & ~flush;
   assign accept = in_valid & in_ready;

   assign iss_rs1 = rs1_q;
   assign iss_rs2 = rs2_q;
   assign iss_rs3 = rs3_q;
   assign iss_rd = rd_q;
   assign iss_imm = imm_q;
   assign iss_func = func_q;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      hold_v_d = hold_v_q;
      if (flush) begin
         hold_v_d = 1'b0;
      end else if (accept) begin
         hold_v_d = 1'b1;
      end else if (fire) begin
         hold_v_d = 1'b0;
      end
   end

   always_comb begin
      div_state_d = div_state_q;
      case (div_state_q)
         D_IDLE: if (fire && is_div) div_state_d = D_BUSY;
         D_BUSY: if (div_done) div_state_d = D_IDLE;
         default: div_state_d = D_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_v_q && hazard && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v_q    <= 1'b0;
         uses_q      <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rs3_q       <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         func_q      <= '0;
         div_state_q <= D_IDLE;
         stall_cnt_q <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         div_state_q <= div_state_d;
         stall_cnt_q <= stall_cnt_d;
         if (accept) begin
            uses_q <= {in_uses_rd, in_uses_rs3, in_uses_rs2, in_uses_rs1};
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
            rs3_q  <= in_rs3;
            rd_q   <= in_rd;
            imm_q  <= in_imm;
            func_q <= in_func;
         end
      end
   end

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Self-checking bench: issued ops are matched in order against a queue of
// expected ops pushed at drive time; each scenario checks its own outputs.
module tb_fp_issue_scoreboard;
   import fp_issue_scoreboard_pkg::*;

   localparam int unsigned AW = 6;
   localparam int unsigned FW = 5;
   localparam int unsigned SW = 16;

   typedef struct packed {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rs3;
      logic [AW-1:0] rd;
      logic [11:0]   imm;
      logic [FW-1:0] func;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_ready;
   logic in_uses_rs1 = 1'b0, in_uses_rs2 = 1'b0, in_uses_rs3 = 1'b0, in_uses_rd = 1'b0;
   logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rs3 = '0, in_rd = '0;
   logic [11:0] in_imm = '0;
   logic [FW-1:0] in_func = '0;
   logic iss_valid, iss_ready = 1'b1;
   logic [AW-1:0] iss_rs1, iss_rs2, iss_rs3, iss_rd;
   logic [11:0] iss_imm;
   logic [FW-1:0] iss_func;
   logic wb_valid = 1'b0;
   logic [AW-1:0] wb_rd = '0;
   logic div_done = 1'b0, flush = 1'b0, div_busy;
   logic [SW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   op_t exp_q[$];
   op_t mon_exp, mon_got;

   always #5 clk = ~clk;

   fp_issue_scoreboard #(
      .VIR_REG_ADDR_WIDTH (AW),
      .FU_FUNC_WIDTH      (FW),
      .STALL_CNT_WIDTH    (SW)
   ) u_dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_uses_rs1 (in_uses_rs1), .in_uses_rs2 (in_uses_rs2),
      .in_uses_rs3 (in_uses_rs3), .in_uses_rd (in_uses_rd),
      .in_rs1 (in_rs1), .in_rs2 (in_rs2), .in_rs3 (in_rs3), .in_rd (in_rd),
      .in_imm (in_imm), .in_func (in_func),
      .iss_valid (iss_valid), .iss_ready (iss_ready),
      .iss_rs1 (iss_rs1), .iss_rs2 (iss_rs2), .iss_rs3 (iss_rs3), .iss_rd (iss_rd),
      .iss_imm (iss_imm), .iss_func (iss_func),
      .wb_valid (wb_valid), .wb_rd (wb_rd),
      .div_done (div_done), .flush (flush),
      .div_busy (div_busy), .stall_cnt (stall_cnt)
   );

   // In-order issue monitor against the expected-op queue.
   always @(negedge clk) begin
      if (!rst && iss_valid && iss_ready) begin
         checks++;
         mon_got = '{iss_rs1, iss_rs2, iss_rs3, iss_rd, iss_imm, iss_func};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected got %h required none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL issue_fields got %h required %h", mon_got, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got running required finished");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic u1, input logic u2, input logic u3, input logic ud,
                           input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [AW-1:0] r3, input logic [AW-1:0] rd,
                           input logic [11:0] imm, input logic [FW-1:0] f);
      in_valid = 1'b1;
      in_uses_rs1 = u1; in_uses_rs2 = u2; in_uses_rs3 = u3; in_uses_rd = ud;
      in_rs1 = r1; in_rs2 = r2; in_rs3 = r3; in_rd = rd;
      in_imm = imm; in_func = f;
      exp_q.push_back('{r1, r2, r3, rd, imm, f});
   endtask

   task automatic wb_pulse(input logic [AW-1:0] a);
      wb_valid = 1'b1; wb_rd = a;
      cyc();
      wb_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid got %b required 0", iss_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
      checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL rst_div_busy got %b required 0", div_busy); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_stall got %0d required 0", stall_cnt); end
      checks++; if ({iss_rs1, iss_rd, iss_imm, iss_func} !== '0) begin
         errors++; $display("FAIL rst_fields got %h required 0", {iss_rs1, iss_rd, iss_imm, iss_func});
      end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] base;
      drive_op(1, 1, 0, 1, 6'd1, 6'd2, 6'd7, 6'd10, 12'h123, FU_FADD);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b required 1", in_ready); end
      cyc();
      drive_op(1, 1, 1, 1, 6'd3, 6'd4, 6'd5, 6'd11, 12'h456, FU_FMADD);
      @(negedge clk);
      checks++; if ({iss_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_op1 got %b required 11", {iss_valid, in_ready}); end
      cyc();
      drive_op(1, 0, 0, 1, 6'd5, 6'd9, 6'd8, 6'd12, 12'hfff, FU_FMUL);
      @(negedge clk);
      checks++; if ({iss_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_op2 got %b required 11", {iss_valid, in_ready}); end
      cyc();
      in_valid = 1'b0; iss_ready = 1'b0; base = stall_cnt;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if ({iss_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL b2b_backpressure got %b required 10", {iss_valid, in_ready}); end
         cyc();
      end
      iss_ready = 1'b1;
      @(negedge clk);
      checks++; if (stall_cnt !== base) begin errors++; $display("FAIL b2b_no_stall got %0d required %0d", stall_cnt, base); end
      cyc();
      @(negedge clk);
      checks++; if ({iss_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_drained got %b required 01", {iss_valid, in_ready}); end
   endtask

   task automatic test_raw();
      logic [SW-1:0] base;
      base = stall_cnt;
      drive_op(0, 0, 0, 1, 6'd1, 6'd2, 6'd3, 6'd33, 12'h001, FU_FADD);
      cyc();
      drive_op(1, 0, 0, 1, 6'd33, 6'd2, 6'd3, 6'd34, 12'h002, FU_FMUL);
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL raw_fadd_issue got %b required 1", iss_valid); end
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b required 0", i, iss_valid); end
         cyc();
      end
      wb_valid = 1'b1; wb_rd = 6'd33;
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL raw_wb_bypass got %b required 1", iss_valid); end
      checks++; if (stall_cnt !== base + 3) begin errors++; $display("FAIL raw_stall_cnt got %0d required %0d", stall_cnt, base + 3); end
      cyc();
      wb_valid = 1'b0;
      @(negedge clk);
      checks++; if (stall_cnt !== base + 3) begin errors++; $display("FAIL raw_stall_hold got %0d required %0d", stall_cnt, base + 3); end
      wb_pulse(6'd34);
   endtask

   task automatic test_div();
      drive_op(1, 1, 0, 1, 6'd40, 6'd41, 6'd0, 6'd45, 12'h000, FU_FDIV);
      cyc();
      drive_op(1, 0, 0, 1, 6'd42, 6'd0, 6'd0, 6'd46, 12'h000, FU_FSQRT);
      @(negedge clk);
      checks++; if ({iss_valid, div_busy} !== 2'b10) begin errors++; $display("FAIL div_fdiv_issue got %b required 10", {iss_valid, div_busy}); end
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if ({iss_valid, div_busy} !== 2'b01) begin errors++; $display("FAIL div_fsqrt_held got %b required 01", {iss_valid, div_busy}); end
         cyc();
      end
      div_done = 1'b1;
      @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL div_done_same_cycle got %b required 0", iss_valid); end
      cyc();
      div_done = 1'b0;
      @(negedge clk);
      checks++; if ({iss_valid, div_busy} !== 2'b10) begin errors++; $display("FAIL div_fsqrt_issue got %b required 10", {iss_valid, div_busy}); end
      cyc();
      @(negedge clk);
      checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL div_fsqrt_busy got %b required 1", div_busy); end
      div_done = 1'b1; cyc(); div_done = 1'b0;
      div_done = 1'b1; cyc(); div_done = 1'b0;
      @(negedge clk);
      checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_idle_done_ignored got %b required 0", div_busy); end
      wb_pulse(6'd45);
      wb_pulse(6'd46);
   endtask

   task automatic test_set_wins();
      drive_op(0, 0, 0, 1, 6'd1, 6'd2, 6'd3, 6'd40, 12'h040, FU_FSUB);
      cyc();
      in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 6'd40;
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL setwins_issue got %b required 1", iss_valid); end
      cyc();
      wb_valid = 1'b0;
      @(negedge clk);
      checks++; if (u_dut.u_sb.sb_q[40] !== 1'b1) begin errors++; $display("FAIL setwins_sb40 got %b required 1", u_dut.u_sb.sb_q[40]); end
      wb_pulse(6'd40);
      @(negedge clk);
      checks++; if (u_dut.u_sb.sb_q[40] !== 1'b0) begin errors++; $display("FAIL setwins_clear got %b required 0", u_dut.u_sb.sb_q[40]); end
   endtask

   task automatic test_rd_zero();
      drive_op(1, 0, 0, 1, 6'd35, 6'd0, 6'd0, 6'd0, 12'h000, FU_FCVT_W_S);
      cyc();
      drive_op(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0, 12'h7ab, FU_FCVT_S_W);
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL rd0_fcvt_issue got %b required 1", iss_valid); end
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL rd0_reader_no_stall got %b required 1", iss_valid); end
      checks++; if (u_dut.u_sb.sb_q[0] !== 1'b0) begin errors++; $display("FAIL rd0_sb0 got %b required 0", u_dut.u_sb.sb_q[0]); end
      cyc();
   endtask

   task automatic test_flush();
      drive_op(0, 0, 0, 1, 6'd1, 6'd2, 6'd3, 6'd50, 12'h050, FU_FMUL);
      cyc();
      drive_op(1, 0, 0, 1, 6'd50, 6'd2, 6'd3, 6'd51, 12'h051, FU_FADD);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_held got %b required 0", iss_valid); end
      cyc();
      flush = 1'b1; in_valid = 1'b1; in_rd = 6'd52; in_func = FU_FSUB;
      @(negedge clk);
      checks++; if ({iss_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL flush_same_cycle got %b required 00", {iss_valid, in_ready}); end
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      checks++; if ({iss_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_empty got %b required 01", {iss_valid, in_ready}); end
      checks++; if (u_dut.u_sb.sb_q[50] !== 1'b1) begin errors++; $display("FAIL flush_sb50 got %b required 1", u_dut.u_sb.sb_q[50]); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pending_issues got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_reset_busy();
      cyc();
      drive_op(0, 0, 0, 1, 6'd1, 6'd2, 6'd3, 6'd47, 12'h000, FU_FDIV);
      cyc();
      drive_op(1, 0, 0, 1, 6'd47, 6'd0, 6'd0, 6'd48, 12'h000, FU_FADD);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if ({div_busy, iss_valid} !== 2'b10) begin errors++; $display("FAIL rstbusy_pre got %b required 10", {div_busy, iss_valid}); end
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++; if ({div_busy, iss_valid, in_ready} !== 3'b001) begin
         errors++; $display("FAIL rstbusy_ctrl got %b required 001", {div_busy, iss_valid, in_ready});
      end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rstbusy_stall got %0d required 0", stall_cnt); end
      checks++; if (u_dut.u_sb.sb_q !== 64'd0) begin errors++; $display("FAIL rstbusy_sb got %h required 0", u_dut.u_sb.sb_q); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_raw();
      test_div();
      test_set_wins();
      test_rd_zero();
      test_flush();
      test_reset_busy();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
